// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - power-up/power-down write sequencer with host write arbitration
module pwr_seq_ctrl #(
  parameter int DELAY = 1000,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power_up,
  input  logic          power_down,
  input  logic          host_valid,
  input  logic [3:0]    host_ch,
  input  logic [7:0]    host_data,
  output logic          host_ready,
  output logic          host_err,
  output logic [20:11]  valid_bus,
  output logic [7:0]    master_data,
  output logic          busy,
  output logic          powered
);

  typedef enum logic [2:0] {OFF, UP_WR, UP_WAIT, ON, DN_WR, DN_WAIT} state_t;

  // Last counter value of a settle wait; unused when DELAY is 0 (wait skipped).
  localparam logic [CNT_W-1:0] WAIT_LAST = (DELAY == 0) ? '0 : CNT_W'(DELAY - 1);

  state_t           state, state_nx;
  logic [1:0]       step, step_nx, step_inc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [9:0]       strobe_nx;
  logic [7:0]       data_nx;
  logic             err_nx;
  logic             is_up, is_wr;

  // Up order: ch19, ch20, ch16, ch17 (bit index = channel - 11).
  function automatic logic [9:0] up_strobe(input logic [1:0] s);
    case (s)
      2'd0:    return 10'b01_0000_0000;
      2'd1:    return 10'b10_0000_0000;
      2'd2:    return 10'b00_0010_0000;
      default: return 10'b00_0100_0000;
    endcase
  endfunction

  // Down order is the reverse: ch17, ch16, ch20, ch19.
  function automatic logic [9:0] down_strobe(input logic [1:0] s);
    case (s)
      2'd0:    return 10'b00_0100_0000;
      2'd1:    return 10'b00_0010_0000;
      2'd2:    return 10'b10_0000_0000;
      default: return 10'b01_0000_0000;
    endcase
  endfunction

  assign host_ready = ((state == OFF) || (state == ON)) && !power_up && !power_down && !rst;
  assign is_up      = (state == UP_WR) || (state == UP_WAIT);
  assign is_wr      = (state == UP_WR) || (state == DN_WR);
  assign step_inc   = step + 2'd1;

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_nx  = state;
    step_nx   = step;
    cnt_nx    = cnt;
    strobe_nx = '0;
    data_nx   = '0;
    err_nx    = 1'b0;
    case (state)
      OFF, ON: begin
        if (state == OFF && power_up && !power_down) begin
          state_nx  = UP_WR;
          step_nx   = 2'd0;
          cnt_nx    = '0;
          strobe_nx = up_strobe(2'd0);
          data_nx   = 8'h01;
        end else if (state == ON && power_down) begin
          state_nx  = DN_WR;
          step_nx   = 2'd0;
          cnt_nx    = '0;
          strobe_nx = down_strobe(2'd0);
        end else if (host_valid && host_ready) begin
          // Channels 16, 17, 19, 20 belong to the sequencer; >9 does not exist.
          if (host_ch inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7}) begin
            strobe_nx = 10'd1 << host_ch;
            data_nx   = host_data;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      UP_WR, UP_WAIT, DN_WR, DN_WAIT: begin
        if (is_up && power_down) begin
          // Abort restarts the complete down sequence from its first write.
          state_nx  = DN_WR;
          step_nx   = 2'd0;
          cnt_nx    = '0;
          strobe_nx = down_strobe(2'd0);
        end else if (is_wr && step == 2'd3) begin
          state_nx = is_up ? ON : OFF;
          cnt_nx   = '0;
        end else if (is_wr && DELAY != 0) begin
          state_nx = is_up ? UP_WAIT : DN_WAIT;
          cnt_nx   = '0;
        end else if (is_wr || cnt == WAIT_LAST) begin
          state_nx  = is_up ? UP_WR : DN_WR;
          step_nx   = step_inc;
          cnt_nx    = '0;
          strobe_nx = is_up ? up_strobe(step_inc) : down_strobe(step_inc);
          data_nx   = is_up ? 8'h01 : 8'h00;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = OFF;
    endcase
  end

  // State, step and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      step  <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bus   <= '0;
      master_data <= '0;
      host_err    <= 1'b0;
      busy        <= 1'b0;
      powered     <= 1'b0;
    end else begin
      valid_bus   <= strobe_nx;
      master_data <= data_nx;
      host_err    <= err_nx;
      busy        <= (state_nx != OFF) && (state_nx != ON);
      powered     <= (state_nx == ON);
    end
  end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - randomized self-checking bench for pwr_seq_ctrl (DELAY=3 and DELAY=0)
module tb_pwr_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, power_up, power_down, host_valid;
  logic [3:0]  host_ch;
  logic [7:0]  host_data;

  logic        hr0, he0, b0, p0, hr1, he1, b1, p1;
  logic [20:11] vb0, vb1;
  logic [7:0]  md0, md1;

  pwr_seq_ctrl #(.DELAY(3), .CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst), .power_up(power_up), .power_down(power_down),
    .host_valid(host_valid), .host_ch(host_ch), .host_data(host_data),
    .host_ready(hr0), .host_err(he0), .valid_bus(vb0), .master_data(md0),
    .busy(b0), .powered(p0));

  pwr_seq_ctrl #(.DELAY(0), .CNT_W(4)) u_d0 (
    .clk(clk), .rst(rst), .power_up(power_up), .power_down(power_down),
    .host_valid(host_valid), .host_ch(host_ch), .host_data(host_data),
    .host_ready(hr1), .host_err(he1), .valid_bus(vb1), .master_data(md1),
    .busy(b1), .powered(p1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each instance is off/up/on/down plus the cycles elapsed
  // since its sequence's first write; strobes fall on multiples of DELAY+1.
  localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3;
  int dl[2] = '{3, 0};
  int up_bit[4] = '{8, 9, 5, 6};
  int dn_bit[4] = '{6, 5, 9, 8};
  int mode[2];
  int t[2];
  logic [9:0] e_vb[2];
  logic [7:0] e_md[2];
  logic       e_busy[2], e_pow[2], e_err[2];

  function automatic bit ch_ok(input logic [3:0] c);
    return (c <= 4'd9) && !(c == 4'd5 || c == 4'd6 || c == 4'd8 || c == 4'd9);
  endfunction

  function automatic logic exp_ready(input int i);
    return (mode[i] == M_OFF || mode[i] == M_ON) && !power_up && !power_down && !rst;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_OFF; t[i] = 0;
      e_vb[i] = '0; e_md[i] = '0; e_busy[i] = 0; e_pow[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit host_ok;
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      e_vb[i] = '0; e_md[i] = '0; e_err[i] = 0;
      host_ok = 0;
      case (mode[i])
        M_OFF: if (power_up && !power_down) begin mode[i] = M_UP; t[i] = 0; end
               else if (!power_up && !power_down) host_ok = 1;
        M_ON:  if (power_down) begin mode[i] = M_DN; t[i] = 0; end
               else if (!power_up) host_ok = 1;
        M_UP:  if (power_down) begin mode[i] = M_DN; t[i] = 0; end
               else begin t[i]++; if (t[i] == 3 * (dl[i] + 1) + 1) mode[i] = M_ON; end
        default: begin t[i]++; if (t[i] == 3 * (dl[i] + 1) + 1) mode[i] = M_OFF; end
      endcase
      if (host_ok && host_valid) begin
        if (ch_ok(host_ch)) begin e_vb[i] = 10'd1 << host_ch; e_md[i] = host_data; end
        else e_err[i] = 1;
      end
      if ((mode[i] == M_UP || mode[i] == M_DN) && (t[i] % (dl[i] + 1) == 0)) begin
        k = t[i] / (dl[i] + 1);
        e_vb[i] = 10'd1 << ((mode[i] == M_UP) ? up_bit[k] : dn_bit[k]);
        e_md[i] = (mode[i] == M_UP) ? 8'h01 : 8'h00;
      end
      e_busy[i] = (mode[i] == M_UP || mode[i] == M_DN);
      e_pow[i]  = (mode[i] == M_ON);
    end
  endtask

  task automatic compare_outputs();
    logic [9:0] vb[2];
    logic [7:0] md[2];
    logic       bz[2], pw[2], er[2];
    vb[0] = vb0; vb[1] = vb1; md[0] = md0; md[1] = md1;
    bz[0] = b0;  bz[1] = b1;  pw[0] = p0;  pw[1] = p1; er[0] = he0; er[1] = he1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("valid_bus%0d", i), 32'(vb[i]), 32'(e_vb[i]));
      check($sformatf("busy%0d", i), 32'(bz[i]), 32'(e_busy[i]));
      check($sformatf("powered%0d", i), 32'(pw[i]), 32'(e_pow[i]));
      check($sformatf("host_err%0d", i), 32'(er[i]), 32'(e_err[i]));
      check($sformatf("onehot%0d", i), 32'($onehot0(vb[i])), 32'd1);
      if (e_vb[i] != '0) check($sformatf("master_data%0d", i), 32'(md[i]), 32'(e_md[i]));
    end
  endtask

  // Called just after a rising edge: drive, check host_ready, clock, check outputs.
  task automatic tick(input logic pu, input logic pd, input logic hv,
                      input logic [3:0] ch, input logic [7:0] d);
    power_up = pu; power_down = pd; host_valid = hv; host_ch = ch; host_data = d;
    #1;
    check("host_ready0", 32'(hr0), 32'(exp_ready(0)));
    check("host_ready1", 32'(hr1), 32'(exp_ready(1)));
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 4'd0, 8'h00);
  endtask

  // Test-plan timeline for one full sequence on both instances.
  task automatic directed_run(input bit up);
    int chs[4];
    logic [9:0] ev0, ev1;
    if (up) chs = '{19, 20, 16, 17};
    else    chs = '{17, 16, 20, 19};
    tick(up, !up, 0, 4'd0, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      ev0 = '0; ev1 = '0;
      if (c % 4 == 1 && c <= 13) ev0 = 10'd1 << (chs[c / 4] - 11);
      if (c <= 4) ev1 = 10'd1 << (chs[c - 1] - 11);
      check("dir_vb_d3", 32'(vb0), 32'(ev0));
      check("dir_busy_d3", 32'(b0), 32'(c <= 13));
      check("dir_pow_d3", 32'(p0), 32'(up && c >= 14));
      if (ev0 != '0) check("dir_md_d3", 32'(md0), up ? 32'h01 : 32'h00);
      check("dir_vb_d0", 32'(vb1), 32'(ev1));
      check("dir_pow_d0", 32'(p1), 32'(up && c >= 5));
      if (c < 14) idle(1);
    end
  endtask

  task automatic async_reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_vb0", 32'(vb0), 32'd0);
    check("rst_busy0", 32'(b0), 32'd0);
    check("rst_ready0", 32'(hr0), 32'd0);
    compare_outputs();
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; power_up = 0; power_down = 0; host_valid = 0; host_ch = '0; host_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    check("ready_in_reset", 32'(hr0), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(hr0), 32'd1);

    directed_run(1'b1);
    idle(1);
    directed_run(1'b0);
    idle(3);

    // Abort: up at cycle 0, down at cycle 6, down write of ch17 at cycle 7.
    tick(1, 0, 0, 4'd0, 8'h00);
    idle(5);
    tick(0, 1, 0, 4'd0, 8'h00);
    check("abort_vb", 32'(vb0), 32'(10'd1 << 6));
    check("abort_md", 32'(md0), 32'h00);
    check("abort_pow", 32'(p0), 32'd0);
    idle(20);

    // Simultaneous requests in OFF do nothing.
    tick(1, 1, 0, 4'd0, 8'h00);
    check("both_off_vb0", 32'(vb0), 32'd0);
    check("both_off_vb1", 32'(vb1), 32'd0);
    check("both_off_busy", 32'(b0), 32'd0);

    // Host writes from OFF.
    tick(0, 0, 1, 4'd0, 8'h0A);
    check("host_ch0_vb", 32'(vb0), 32'd1);
    check("host_ch0_md", 32'(md0), 32'h0A);
    tick(0, 0, 1, 4'd8, 8'h33);
    check("host_ch8_err", 32'(he0), 32'd1);
    check("host_ch8_vb", 32'(vb0), 32'd0);
    tick(0, 0, 1, 4'd12, 8'h44);
    check("host_ch12_err", 32'(he0), 32'd1);

    // Host write while busy, then reset in the middle of the sequence.
    tick(1, 0, 0, 4'd0, 8'h00);
    tick(0, 0, 1, 4'd0, 8'h55);
    check("busy_host_vb", 32'(vb0), 32'd0);
    idle(2);
    async_reset_pulse();
    idle(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
      else tick($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
- Sits in front of the FPGA register block and is the only driver of that block's write strobe bus (valid_bus[20:11]) and data byte (master_data).
- Runs the fixed power-up and power-down write sequences for the BOS supply and level-translator controls, with a programmable settle delay between writes.
- When no sequence is running, it arbitrates host register writes onto the same bus.

Parameters:
- DELAY, 1000: idle cycles inserted after each sequence write before the next write (0 = back-to-back writes).
- CNT_W, 16: width of the settle counter. Requires DELAY < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- power_up  in  1  single-cycle request to run the power-up sequence.
- power_down  in  1  single-cycle request to run the power-down sequence.
- host_valid  in  1  host write request.
- host_ch  in  4  target channel index; 0..9 maps to register channels 11..20.
- host_data  in  8  host write data.
- host_ready  out  1  host write is accepted this cycle (combinational).
- host_err  out  1  one-cycle pulse when an accepted host write is dropped.
- valid_bus  out  10 ([20:11])  one-hot write strobe to the register block.
- master_data  out  8  write data, valid while a strobe is high.
- busy  out  1  a sequence is in progress.
- powered  out  1  the power-up sequence has completed.

Behaviour:
- Reset (async, rst=1): valid_bus=0, master_data=0, busy=0, powered=0, host_err=0, state=OFF, counter=0. While in reset, host_ready=0.
- States: OFF, UP_WR, UP_WAIT, ON, DN_WR, DN_WAIT. A step index (0..3) selects the write for the current step.
- Up order (data 0x01): ch19 vcore, ch20 vdigital, ch16 pr_digital, ch17 functional.
- Down order (data 0x00): ch17, ch16, ch20, ch19.
- All outputs except host_ready are registered.
- Sequence start: a request sampled at cycle N puts the first write strobe out at N+1.
  - Each *_WR state lasts 1 cycle: one strobe bit high, with master_data set.
  - Each *_WAIT state lasts exactly DELAY cycles with valid_bus=0. If DELAY=0, the WAIT state is skipped.
  - Step k therefore writes at N+1+k*(DELAY+1).
- busy is high from the first write cycle through the last write cycle inclusive.
- powered:
  - Rises the cycle after the final up write (ch17), entering ON.
  - Falls in the cycle of the first down write.
  - After the final down write (ch19), the state returns to OFF.
- Request rules:
  - power_up is accepted only in OFF; it is ignored in all other states.
  - power_down is accepted in ON, UP_WR and UP_WAIT; it is ignored in OFF and in the down states.
  - power_down during the up sequence aborts it. The next cycle starts the full 4-step down sequence from step 0, with the counter cleared.
  - If power_up and power_down arrive in the same cycle, power_down wins. In OFF, both are ignored.
- Host arbitration:
  - host_ready = (state is OFF or ON) & !power_up & !power_down & !rst.
  - A write is accepted when host_valid & host_ready. In the next cycle, valid_bus[11+host_ch] pulses with master_data=host_data.
  - Drop case 1: host_ch in {5,6,8,9} (channels 16, 17, 19, 20 are owned by the sequencer). The write is dropped: no strobe, and host_err pulses the next cycle.
  - Drop case 2: host_ch > 9. The write is dropped and host_err pulses the next cycle.
  - When host_ready=0, host_valid has no effect and is not queued.
- At most one valid_bus bit is high in any cycle.
- Reset mid-sequence: all outputs clear immediately and the state returns to OFF. The sequence does not resume.

Test Plan:
- Reset: assert rst mid-run -> all registered outputs 0 within the same cycle; after release, host_ready=1, state OFF.
- Power-up, DELAY=3, power_up at cycle 0 -> strobes as follows, with busy=1 over cycles 1..13 and powered=1 from cycle 14:
  - cycle 1: valid_bus[19], master_data 0x01
  - cycle 5: valid_bus[20]
  - cycle 9: valid_bus[16]
  - cycle 13: valid_bus[17]
- Power-down from ON, DELAY=3, power_down at cycle 0 -> strobes below, all with master_data 0x00; powered=0 from cycle 1; busy low at cycle 14:
  - cycle 1: valid_bus[17]
  - cycle 5: valid_bus[16]
  - cycle 9: valid_bus[20]
  - cycle 13: valid_bus[19]
- Abort: power_up at cycle 0, power_down at cycle 6 -> cycle 7 brings valid_bus[17]=0x00, followed by the full down sequence; powered never rises; simultaneous up+down in OFF produces no strobe.
- Host writes:
  - In OFF, host_ch=0, data 0x0A -> valid_bus[11] with 0x0A the next cycle.
  - host_ch=8 -> no strobe, host_err pulse.
  - host_ch=12 -> host_err pulse.
  - host_valid during busy -> host_ready=0, no strobe.
- DELAY=0 power-up -> strobes back-to-back on cycles 1, 2, 3, 4; powered=1 at cycle 5.
